// File: rtl/song_pkg.sv
// song_pkg: shared constants for the song player.
//   - key ID constants (REST, NOTE_C4..NOTE_B4, chromatic 1..12)
//   - tempo_sel encodings
//   - default score entry field widths
//   - sequencer state enum
package song_pkg;

    localparam int KEY_W = 4;  // default key_id field width
    localparam int DUR_W = 4;  // default duration field width

    localparam logic [3:0] REST     = 4'd0;
    localparam logic [3:0] NOTE_C4  = 4'd1;
    localparam logic [3:0] NOTE_CS4 = 4'd2;
    localparam logic [3:0] NOTE_D4  = 4'd3;
    localparam logic [3:0] NOTE_DS4 = 4'd4;
    localparam logic [3:0] NOTE_E4  = 4'd5;
    localparam logic [3:0] NOTE_F4  = 4'd6;
    localparam logic [3:0] NOTE_FS4 = 4'd7;
    localparam logic [3:0] NOTE_G4  = 4'd8;
    localparam logic [3:0] NOTE_GS4 = 4'd9;
    localparam logic [3:0] NOTE_A4  = 4'd10;
    localparam logic [3:0] NOTE_AS4 = 4'd11;
    localparam logic [3:0] NOTE_B4  = 4'd12;

    localparam logic [1:0] TEMPO_1X     = 2'd0;
    localparam logic [1:0] TEMPO_FAST   = 2'd1;  // unit / 2
    localparam logic [1:0] TEMPO_SLOW   = 2'd2;  // unit * 2
    localparam logic [1:0] TEMPO_1X_ALT = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_NOTE,
        ST_GAP
    } state_e;

endpackage

// File: rtl/song_rom.sv
// song_rom: shared score ROM with a 1-cycle registered read.
//   clk_i, rst_n_i : clock, async active-low reset
//   song_i         : song index for the start-address table
//   start_addr_o   : first entry of song_i (combinational table lookup)
//   addr_i         : read address, captured every clock
//   dur_o, key_o   : entry read at the previous edge ({duration, key_id})
// Layout: Twinkle at 0 (14 notes + marker), chromatic C4..B4 at 15
// (12 notes + marker), then one bare marker per remaining song.
module song_rom
    import song_pkg::*;
#(
    parameter int KEY_ID_BITS   = KEY_W,
    parameter int DURATION_BITS = DUR_W,
    parameter int NUM_SONGS     = 4,
    parameter int ROM_DEPTH     = 128,
    localparam int AW = $clog2(ROM_DEPTH),
    localparam int SW = $clog2(NUM_SONGS)
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic [SW-1:0]            song_i,
    output logic [AW-1:0]            start_addr_o,
    input  logic [AW-1:0]            addr_i,
    output logic [DURATION_BITS-1:0] dur_o,
    output logic [KEY_ID_BITS-1:0]   key_o
);
    localparam int TW_LEN     = 14;
    localparam int TI_W       = $clog2(TW_LEN);
    localparam int SCALE_BASE = TW_LEN + 1;
    localparam int SCALE_LEN  = 12;
    localparam int MARK_BASE  = SCALE_BASE + SCALE_LEN + 1;

    localparam logic [3:0] TW_KEY [TW_LEN] = '{
        NOTE_C4, NOTE_C4, NOTE_G4, NOTE_G4, NOTE_A4, NOTE_A4, NOTE_G4,
        NOTE_F4, NOTE_F4, NOTE_E4, NOTE_E4, NOTE_D4, NOTE_D4, NOTE_C4};
    localparam logic [3:0] TW_DUR [TW_LEN] = '{
        4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd2,
        4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd2};

    // Unlisted addresses read as duration 0, i.e. an end marker.
    function automatic logic [DURATION_BITS+KEY_ID_BITS-1:0] entry(input int a);
        entry = '0;
        if (a < TW_LEN)
            entry = {DURATION_BITS'(TW_DUR[TI_W'(a)]), KEY_ID_BITS'(TW_KEY[TI_W'(a)])};
        else if (a >= SCALE_BASE && a < SCALE_BASE + SCALE_LEN)
            entry = {DURATION_BITS'(1), KEY_ID_BITS'(a - SCALE_BASE + int'(NOTE_C4))};
    endfunction

    logic [DURATION_BITS+KEY_ID_BITS-1:0] rd_q;

    always_comb begin
        start_addr_o = AW'(MARK_BASE + int'(song_i) - 2);
        if (song_i == '0)           start_addr_o = '0;
        else if (song_i == SW'(1))  start_addr_o = AW'(SCALE_BASE);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) rd_q <= '0;
        else          rd_q <= entry(int'(addr_i));
    end

    assign {dur_o, key_o} = rd_q;

endmodule

// File: rtl/song_sequencer.sv
// song_sequencer: plays the selected ROM song with tempo, articulation
// gap, pause and loop.
//   clk, rst_n          : clock, async active-low reset
//   play_level          : level; rising edge starts, low stops
//   song_sel            : song index, latched at start
//   loop_en, pause      : live controls
//   tempo_sel           : 0/3 = 1x, 1 = unit/2, 2 = unit*2
//   song_key_id         : current note ID
//   song_key_is_pressed : note sounding
//   is_song_playing     : any state but IDLE
//   note_index          : ROM address of current entry
//   song_done           : 1-cycle pulse at each song end
module song_sequencer
    import song_pkg::*;
#(
    parameter int CLK_FREQ_HZ   = 50_000_000,
    parameter int KEY_ID_BITS   = KEY_W,
    parameter int DURATION_BITS = DUR_W,
    parameter int NUM_SONGS     = 4,
    parameter int ROM_DEPTH     = 128,
    parameter int UNIT_MS       = 100,
    parameter int GAP_MS        = 10,
    localparam int AW = $clog2(ROM_DEPTH),
    localparam int SW = $clog2(NUM_SONGS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   play_level,
    input  logic [SW-1:0]          song_sel,
    input  logic                   loop_en,
    input  logic                   pause,
    input  logic [1:0]             tempo_sel,
    output logic [KEY_ID_BITS-1:0] song_key_id,
    output logic                   song_key_is_pressed,
    output logic                   is_song_playing,
    output logic [AW-1:0]          note_index,
    output logic                   song_done
);
    localparam int CYC_PER_MS = CLK_FREQ_HZ / 1000;
    localparam int UNIT_CYC   = UNIT_MS * CYC_PER_MS;
    localparam int GAP_CYC    = GAP_MS * CYC_PER_MS;
    localparam int TW = $clog2(2 * UNIT_CYC * (2**DURATION_BITS - 1) + 1);

    state_e                   state_q;
    logic [TW-1:0]            timer_q;
    logic [SW-1:0]            song_q;
    logic [AW-1:0]            addr_q;
    logic                     wait_q;      // first FETCH cycle: read in flight
    logic                     play_q;
    logic                     armed_q;     // play_q holds a real post-reset sample
    logic                     sounding_q;  // pressed value of the current note
    logic [KEY_ID_BITS-1:0]   key_q;
    logic                     pressed_q, playing_q, done_q;
    logic [AW-1:0]            idx_q;

    logic [SW-1:0]            rom_song;
    logic [AW-1:0]            start_addr;
    logic [DURATION_BITS-1:0] rom_dur;
    logic [KEY_ID_BITS-1:0]   rom_key;
    logic                     play_rise, rom_end, entry_ready;
    logic [TW-1:0]            unit_cyc, note_len_d;

    // Until the song is latched, the start table follows song_sel.
    assign rom_song = (state_q == ST_IDLE) ? song_sel : song_q;

    song_rom #(
        .KEY_ID_BITS(KEY_ID_BITS), .DURATION_BITS(DURATION_BITS),
        .NUM_SONGS(NUM_SONGS), .ROM_DEPTH(ROM_DEPTH)
    ) u_rom (
        .clk_i(clk), .rst_n_i(rst_n), .song_i(rom_song),
        .start_addr_o(start_addr), .addr_i(addr_q),
        .dur_o(rom_dur), .key_o(rom_key)
    );

    // Without armed_q a play level held through reset would look like a rise.
    assign play_rise = play_level & ~play_q & armed_q;
    assign rom_end   = (rom_dur == '0) || (addr_q == AW'(ROM_DEPTH - 1));

    // ROM data matches addr_q when FETCH's second cycle or a GAP ends;
    // GAP_CYC >= 2 leaves room for the prefetch issued on entering GAP.
    assign entry_ready = (state_q == ST_FETCH && !wait_q) ||
                         (state_q == ST_GAP && !pause && timer_q == '0);

    always_comb begin
        unit_cyc = TW'(UNIT_CYC);
        case (tempo_sel)
            TEMPO_FAST: unit_cyc = TW'(UNIT_CYC) >> 1;
            TEMPO_SLOW: unit_cyc = TW'(UNIT_CYC) << 1;
            default:    unit_cyc = TW'(UNIT_CYC);
        endcase
        // Sounding part of the note, minus one for the terminal zero count.
        note_len_d = TW'(rom_dur) * unit_cyc - TW'(GAP_CYC + 1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            song_q     <= '0;
            addr_q     <= '0;
            wait_q     <= 1'b0;
            play_q     <= 1'b0;
            armed_q    <= 1'b0;
            sounding_q <= 1'b0;
            key_q      <= '0;
            pressed_q  <= 1'b0;
            playing_q  <= 1'b0;
            idx_q      <= '0;
            done_q     <= 1'b0;
        end else begin
            play_q  <= play_level;
            armed_q <= 1'b1;
            done_q  <= 1'b0;
            if (state_q != ST_IDLE && !play_level) begin
                state_q    <= ST_IDLE;
                timer_q    <= '0;
                sounding_q <= 1'b0;
                key_q      <= '0;
                pressed_q  <= 1'b0;
                playing_q  <= 1'b0;
                idx_q      <= '0;
            end else begin
                unique case (state_q)
                    ST_IDLE: if (play_rise) begin
                        song_q    <= song_sel;
                        addr_q    <= start_addr;
                        idx_q     <= start_addr;
                        wait_q    <= 1'b1;
                        playing_q <= 1'b1;
                        state_q   <= ST_FETCH;
                    end
                    ST_FETCH: wait_q <= 1'b0;
                    ST_NOTE: begin
                        if (pause) begin
                            pressed_q <= 1'b0;
                        end else if (timer_q == '0) begin
                            state_q   <= ST_GAP;
                            timer_q   <= TW'(GAP_CYC - 1);
                            pressed_q <= 1'b0;
                            addr_q    <= addr_q + 1'b1;  // prefetch next entry
                        end else begin
                            timer_q   <= timer_q - 1'b1;
                            pressed_q <= sounding_q;
                        end
                    end
                    ST_GAP: if (!pause && timer_q != '0) timer_q <= timer_q - 1'b1;
                endcase

                if (entry_ready) begin
                    if (rom_end) begin
                        done_q    <= 1'b1;
                        pressed_q <= 1'b0;
                        if (loop_en) begin
                            state_q <= ST_FETCH;
                            wait_q  <= 1'b1;
                            addr_q  <= start_addr;
                            idx_q   <= start_addr;
                        end else begin
                            state_q    <= ST_IDLE;
                            timer_q    <= '0;
                            sounding_q <= 1'b0;
                            key_q      <= '0;
                            playing_q  <= 1'b0;
                            idx_q      <= '0;
                        end
                    end else begin
                        state_q    <= ST_NOTE;
                        key_q      <= rom_key;
                        sounding_q <= (rom_key != KEY_ID_BITS'(REST));
                        pressed_q  <= (rom_key != KEY_ID_BITS'(REST)) && !pause;
                        idx_q      <= addr_q;
                        timer_q    <= note_len_d;  // tempo sampled per note
                    end
                end
            end
        end
    end

    assign song_key_id         = key_q;
    assign song_key_is_pressed = pressed_q;
    assign is_song_playing     = playing_q;
    assign note_index          = idx_q;
    assign song_done           = done_q;

endmodule

// File: tb/tb_song_sequencer.sv
// Bench for song_sequencer at CLK_FREQ_HZ = 10_000, GAP_MS = 1
// (UNIT_CYC = 1000, GAP_CYC = 10). Expectations are queued with the
// absolute cycle they apply to and compared on the falling edge.
module tb_song_sequencer;
    localparam int MK = 1, MP = 2, ML = 4, MD = 8, MI = 16, MALL = 31;

    logic       clk = 1'b0, rst_n = 1'b0, play_level = 1'b0;
    logic       loop_en = 1'b0, pause = 1'b0;
    logic [1:0] song_sel = 2'd0, tempo_sel = 2'd0;
    logic [3:0] song_key_id;
    logic       song_key_is_pressed, is_song_playing, song_done;
    logic [6:0] note_index;

    song_sequencer #(.CLK_FREQ_HZ(10_000), .GAP_MS(1)) dut (
        .clk(clk), .rst_n(rst_n), .play_level(play_level), .song_sel(song_sel),
        .loop_en(loop_en), .pause(pause), .tempo_sel(tempo_sel),
        .song_key_id(song_key_id), .song_key_is_pressed(song_key_is_pressed),
        .is_song_playing(is_song_playing), .note_index(note_index),
        .song_done(song_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc; int key; int pr; int pl; int dn; int idx; int msk; string nm;
    } exp_t;
    typedef struct {
        int off; int key; int pr; int pl; int dn; int idx; int msk; string nm;
    } vec_t;

    exp_t  sb[$];
    vec_t  tab[8];
    int    checks = 0, failures = 0, done_cnt = 0;
    int    T, E;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d (cycle %0d)", nm, act, want, cyc);
        end
    endtask

    function automatic exp_t mk(int c, int k, int pr, int pl, int dn, int ix, int m, string nm);
        mk.cyc = c; mk.key = k; mk.pr = pr; mk.pl = pl; mk.dn = dn;
        mk.idx = ix; mk.msk = m; mk.nm = nm;
    endfunction

    task automatic push(exp_t e);
        int i = 0;
        while (i < sb.size() && sb[i].cyc <= e.cyc) i++;
        sb.insert(i, e);
    endtask

    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (song_done) done_cnt++;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            if (e.cyc < cyc) chk({e.nm, ".late"}, cyc, e.cyc);
            else begin
                if ((e.msk & MK) != 0) chk({e.nm, ".key"}, song_key_id, e.key);
                if ((e.msk & MP) != 0) chk({e.nm, ".pressed"}, song_key_is_pressed, e.pr);
                if ((e.msk & ML) != 0) chk({e.nm, ".playing"}, is_song_playing, e.pl);
                if ((e.msk & MD) != 0) chk({e.nm, ".done"}, song_done, e.dn);
                if ((e.msk & MI) != 0) chk({e.nm, ".index"}, note_index, e.idx);
            end
        end
    endtask

    task automatic wait_drain(int budget);
        for (int i = 0; i < budget && sb.size() > 0; i++) tick();
        if (sb.size() > 0) begin
            chk("scoreboard_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic run_to(int c);
        while (cyc < c) tick();
    endtask

    initial begin
        // Song 0 at 1x: checkpoints relative to the sampled play rise.
        tab[0] = '{1,    0, 0, 1, 0, 0, MP | ML, "s0.fetch"};
        tab[1] = '{2,    1, 1, 1, 0, 0, MALL,    "s0.n0_on"};
        tab[2] = '{991,  1, 1, 1, 0, 0, MALL,    "s0.n0_last"};
        tab[3] = '{992,  1, 0, 1, 0, 0, MALL,    "s0.n0_gap"};
        tab[4] = '{1001, 1, 0, 1, 0, 0, MALL,    "s0.gap_end"};
        tab[5] = '{1002, 1, 1, 1, 0, 1, MALL,    "s0.n1_on"};
        tab[6] = '{1992, 1, 0, 1, 0, 1, MALL,    "s0.n1_gap"};
        tab[7] = '{2002, 8, 1, 1, 0, 2, MALL,    "s0.n2_on"};

        repeat (3) tick();
        chk("rst.key", song_key_id, 0);
        chk("rst.pressed", song_key_is_pressed, 0);
        chk("rst.playing", is_song_playing, 0);
        chk("rst.index", note_index, 0);
        chk("rst.done", song_done, 0);
        rst_n = 1'b1;
        repeat (5) tick();

        // Song 0, tempo 1x, then stop mid-note and restart.
        T = cyc + 1; play_level = 1'b1;
        for (int i = 0; i < 8; i++)
            push(mk(T + tab[i].off, tab[i].key, tab[i].pr, tab[i].pl, tab[i].dn,
                    tab[i].idx, tab[i].msk, tab[i].nm));
        wait_drain(2100);
        play_level = 1'b0;
        push(mk(cyc + 1, 0, 0, 0, 0, 0, MALL, "stop"));
        wait_drain(4);
        repeat (3) tick();
        T = cyc + 1; play_level = 1'b1;
        push(mk(T + 2, 1, 1, 1, 0, 0, MALL, "restart"));
        wait_drain(4);
        play_level = 1'b0;
        repeat (3) tick();

        // Song 1 (chromatic scale) at 2x, no loop.
        song_sel = 2'd1; tempo_sel = 2'd1; done_cnt = 0;
        T = cyc + 1; play_level = 1'b1;
        push(mk(T + 1, 0, 0, 1, 0, 0, MP | ML, "scale.fetch"));
        for (int i = 0; i < 12; i++) begin
            E = T + 2 + 500 * i;
            push(mk(E,       i + 1, 1, 1, 0, 15 + i, MALL, "scale.on"));
            push(mk(E + 489, i + 1, 1, 1, 0, 15 + i, MALL, "scale.last"));
            push(mk(E + 490, i + 1, 0, 1, 0, 15 + i, MALL, "scale.gap"));
        end
        E = T + 6002;
        push(mk(E,     0, 0, 0, 1, 0, MALL,         "scale.end"));
        push(mk(E + 1, 0, 0, 0, 0, 0, MP | ML | MD, "scale.idle"));
        wait_drain(6100);
        repeat (3) tick();
        chk("scale.done_count", done_cnt, 1);
        chk("scale.still_idle", is_song_playing, 0);

        // Song 1 at 2x with loop: wrap without an IDLE cycle.
        play_level = 1'b0; loop_en = 1'b1;
        repeat (2) tick();
        done_cnt = 0;
        T = cyc + 1; play_level = 1'b1;
        E = T + 6002;
        push(mk(E,     0, 0, 1, 1, 0,  MP | ML | MD, "loop.wrap"));
        push(mk(E + 1, 0, 0, 1, 0, 0,  MP | ML | MD, "loop.fetch"));
        push(mk(E + 2, 1, 1, 1, 0, 15, MALL,         "loop.first"));
        wait_drain(6100);
        chk("loop.done_count", done_cnt, 1);
        play_level = 1'b0; loop_en = 1'b0;
        repeat (3) tick();

        // Pause 300 cycles mid-note on song 0 at 1x.
        song_sel = 2'd0; tempo_sel = 2'd0;
        T = cyc + 1; play_level = 1'b1;
        push(mk(T + 2,   1, 1, 1, 0, 0, MALL, "pause.pre"));
        push(mk(T + 501, 1, 0, 1, 0, 0, MALL, "pause.start"));
        push(mk(T + 650, 1, 0, 1, 0, 0, MALL, "pause.mid"));
        push(mk(T + 800, 1, 0, 1, 0, 0, MALL, "pause.last"));
        run_to(T + 500);
        pause = 1'b1;
        run_to(T + 800);
        pause = 1'b0;
        push(mk(T + 801,  1, 1, 1, 0, 0, MALL, "pause.resume"));
        push(mk(T + 1291, 1, 1, 1, 0, 0, MALL, "pause.n0_last"));
        push(mk(T + 1292, 1, 0, 1, 0, 0, MALL, "pause.n0_gap"));
        push(mk(T + 1302, 1, 1, 1, 0, 1, MALL, "pause.n1_on"));
        wait_drain(600);
        play_level = 1'b0;
        repeat (3) tick();

        // Play rising while pause is already high.
        pause = 1'b1;
        T = cyc + 1; play_level = 1'b1;
        push(mk(T + 1,  0, 0, 1, 0, 0, MP | ML, "pstart.fetch"));
        push(mk(T + 2,  1, 0, 1, 0, 0, MALL,    "pstart.held"));
        push(mk(T + 50, 1, 0, 1, 0, 0, MALL,    "pstart.still"));
        run_to(T + 60);
        pause = 1'b0;
        push(mk(T + 61, 1, 1, 1, 0, 0, MALL, "pstart.release"));
        wait_drain(5);
        play_level = 1'b0;
        repeat (3) tick();

        // Asynchronous reset mid-note, play held high across it.
        T = cyc + 1; play_level = 1'b1;
        run_to(T + 100);
        chk("arst.pre_pressed", song_key_is_pressed, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst.key", song_key_id, 0);
        chk("arst.pressed", song_key_is_pressed, 0);
        chk("arst.playing", is_song_playing, 0);
        chk("arst.index", note_index, 0);
        chk("arst.done", song_done, 0);
        tick();
        rst_n = 1'b1;
        repeat (20) tick();
        chk("arst.no_start_playing", is_song_playing, 0);
        chk("arst.no_start_pressed", song_key_is_pressed, 0);
        chk("arst.no_start_key", song_key_id, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
